// File: rtl/fib_datapath_pkg.sv
// fib_datapath_pkg: opcode encoding and register index names shared by fsm and datapath
package fib_datapath_pkg;
    localparam int OPW = 3;
    typedef enum logic [OPW-1:0] {
        OP_NOP = 3'b000,
        OP_LDN = 3'b001,
        OP_CLR = 3'b010,
        OP_INC = 3'b011,
        OP_DEC = 3'b100,
        OP_MOV = 3'b101,
        OP_ADD = 3'b110,
        OP_OUT = 3'b111
    } op_t;
    localparam logic [1:0] R_A   = 2'd0;
    localparam logic [1:0] R_B   = 2'd1;
    localparam logic [1:0] R_CNT = 2'd2;
    localparam logic [1:0] R_TMP = 2'd3;
endpackage

// File: rtl/fib_datapath_regfile.sv
// fib_datapath_regfile: 2**AW x WIDTH registers, two async read ports, one sync write port
//   clk/rst: clock, sync active-high reset; we/wa/wd: write port; ra/rb -> rda/rdb: read ports
module fib_datapath_regfile #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    output logic [WIDTH-1:0] rda,
    output logic [WIDTH-1:0] rdb
);
    logic [WIDTH-1:0] r [2**AW];

    always_ff @(posedge clk) begin
        if (rst) r <= '{default: '0};
        else if (we) r[wa] <= wd;
    end

    assign rda = r[ra];
    assign rdb = r[rb];
endmodule

// File: rtl/fib_datapath.sv
// fib_datapath: register file + single-op ALU executing fsm opcodes to compute F(N)
//   CLK/RST: clock, sync active-high reset; opcode/operand1(rd)/operand2(rs): fsm command
//   N_IN: loop count for LDN; ZERO_FLAG: last written value was 0; OVERFLOW: sticky carry
//   RESULT/RESULT_VALID: value captured by OUT and its one-cycle strobe
module fib_datapath
    import fib_datapath_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [SIZE-2:0]  opcode,
    input  logic [SIZE-3:0]  operand1,
    input  logic [SIZE-3:0]  operand2,
    input  logic [WIDTH-1:0] N_IN,
    output logic             ZERO_FLAG,
    output logic             OVERFLOW,
    output logic [WIDTH-1:0] RESULT,
    output logic             RESULT_VALID
);
    op_t              op;
    logic [WIDTH-1:0] a, b, wd;
    logic [WIDTH:0]   sum;
    logic             we, carry;

    fib_datapath_regfile #(.WIDTH(WIDTH), .AW(SIZE-2)) u_rf (
        .clk(CLK),
        .rst(RST),
        .we (we),
        .wa (operand1),
        .wd (wd),
        .ra (operand1),
        .rb (operand2),
        .rda(a),
        .rdb(b)
    );

    assign op = op_t'(opcode);

    // INC and ADD share one adder so both produce the carry that feeds OVERFLOW
    always_comb begin
        sum   = {1'b0, a} + (op == OP_ADD ? {1'b0, b} : (WIDTH+1)'(1));
        we    = op != OP_NOP && op != OP_OUT;
        carry = (op == OP_ADD || op == OP_INC) && sum[WIDTH];
        wd    = op == OP_LDN ? N_IN :
                op == OP_CLR ? '0 :
                op == OP_DEC ? a - 1'b1 :
                op == OP_MOV ? b : sum[WIDTH-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ZERO_FLAG    <= 1'b0;
            OVERFLOW     <= 1'b0;
            RESULT       <= '0;
            RESULT_VALID <= 1'b0;
        end else begin
            RESULT_VALID <= op == OP_OUT;
            if (op == OP_OUT) RESULT <= a;
            if (we) ZERO_FLAG <= wd == '0;
            if (carry) OVERFLOW <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fib_datapath.sv
// tb_fib_datapath: directed scoreboard bench for fib_datapath
module tb_fib_datapath;
    import fib_datapath_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] operand1 = 2'd0;
    logic [1:0] operand2 = 2'd0;
    logic [7:0] N_IN = 8'd0;
    logic       ZERO_FLAG, OVERFLOW, RESULT_VALID;
    logic [7:0] RESULT;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [$];

    fib_datapath #(.SIZE(4), .WIDTH(8)) dut (
        .CLK(CLK),
        .RST(RST),
        .opcode(opcode),
        .operand1(operand1),
        .operand2(operand2),
        .N_IN(N_IN),
        .ZERO_FLAG(ZERO_FLAG),
        .OVERFLOW(OVERFLOW),
        .RESULT(RESULT),
        .RESULT_VALID(RESULT_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: every RESULT_VALID must match the oldest outstanding OUT
    always @(negedge CLK) begin
        if (RESULT_VALID) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected: got valid with RESULT=%0d, expected no output", RESULT);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (RESULT !== e) begin
                    errors++;
                    $display("FAIL result: got %0d expected %0d", RESULT, e);
                end
            end
        end
    end

    task automatic issue(input op_t op, input logic [1:0] rd, input logic [1:0] rs = 2'd0);
        opcode = op;
        operand1 = rd;
        operand2 = rs;
        @(posedge CLK);
        #1;
        opcode = OP_NOP;
    endtask

    task automatic out(input logic [1:0] rd, input logic [7:0] exp);
        sb.push_back(exp);
        issue(OP_OUT, rd);
    endtask

    // reset while an ADD R0,R1 is presented: reset must win
    task automatic do_reset();
        RST = 1'b1;
        opcode = OP_ADD;
        operand1 = 2'd0;
        operand2 = 2'd1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        opcode = OP_NOP;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_zf"}, ZERO_FLAG, 0);
        chk({tag, "_ovf"}, OVERFLOW, 0);
        chk({tag, "_result"}, RESULT, 0);
        chk({tag, "_valid"}, RESULT_VALID, 0);
        out(R_A, 8'd0);
        out(R_B, 8'd0);
        out(R_CNT, 8'd0);
        out(R_TMP, 8'd0);
        issue(OP_NOP, 2'd0);
    endtask

    // stop_after >= 0 abandons the loop after that many iterations
    task automatic fib(input logic [7:0] n, input int stop_after, output int iters);
        N_IN = n;
        issue(OP_CLR, R_A);
        issue(OP_CLR, R_B);
        issue(OP_INC, R_B);
        issue(OP_LDN, R_CNT);
        iters = 0;
        do begin
            issue(OP_MOV, R_TMP, R_B);
            issue(OP_ADD, R_B, R_A);
            issue(OP_MOV, R_A, R_TMP);
            issue(OP_DEC, R_CNT);
            iters++;
            if (iters == stop_after) return;
        end while (!ZERO_FLAG && iters < 300);
    endtask

    initial begin
        int it;
        // 1: reset with ADD presented
        do_reset();
        check_cleared("rst");

        // 2: LDN/DEC zero detection
        N_IN = 8'd1;
        issue(OP_LDN, R_CNT);
        chk("ldn_zf", ZERO_FLAG, 0);
        issue(OP_DEC, R_CNT);
        chk("dec_zf", ZERO_FLAG, 1);
        issue(OP_NOP, 2'd0);
        chk("nop_hold_zf", ZERO_FLAG, 1);
        out(R_CNT, 8'd0);
        chk("out_hold_zf", ZERO_FLAG, 1);

        // 3: F(10)
        fib(8'd10, -1, it);
        chk("fib10_iters", it, 10);
        out(R_A, 8'd55);
        chk("fib10_valid", RESULT_VALID, 1);
        issue(OP_NOP, 2'd0);
        chk("fib10_pulse_end", RESULT_VALID, 0);
        chk("fib10_ovf", OVERFLOW, 0);

        // back-to-back OUTs keep valid high and update RESULT each cycle
        out(R_A, 8'd55);
        out(R_B, 8'd89);
        chk("b2b_valid", RESULT_VALID, 1);
        issue(OP_NOP, 2'd0);

        // ADD R0,R0 doubles using the pre-edge value; MOV R1,R1 still updates ZERO_FLAG
        N_IN = 8'd3;
        issue(OP_LDN, R_A);
        issue(OP_ADD, R_A, R_A);
        out(R_A, 8'd6);
        issue(OP_CLR, R_B);
        issue(OP_LDN, R_CNT);
        chk("ldn3_zf", ZERO_FLAG, 0);
        issue(OP_MOV, R_B, R_B);
        chk("mov_self_zf", ZERO_FLAG, 1);

        // 4: ADD carry
        N_IN = 8'd200;
        issue(OP_LDN, R_A);
        N_IN = 8'd100;
        issue(OP_LDN, R_B);
        issue(OP_ADD, R_A, R_B);
        chk("add_ovf", OVERFLOW, 1);
        chk("add_zf", ZERO_FLAG, 0);
        out(R_A, 8'd44);
        issue(OP_NOP, 2'd0);
        chk("ovf_sticky", OVERFLOW, 1);
        do_reset();
        chk("rst_ovf", OVERFLOW, 0);

        // 5: DEC/INC wrap
        issue(OP_CLR, R_TMP);
        issue(OP_DEC, R_TMP);
        chk("dec_wrap_zf", ZERO_FLAG, 0);
        chk("dec_wrap_ovf", OVERFLOW, 0);
        out(R_TMP, 8'd255);
        issue(OP_INC, R_TMP);
        chk("inc_wrap_zf", ZERO_FLAG, 1);
        chk("inc_wrap_ovf", OVERFLOW, 1);
        out(R_TMP, 8'd0);
        issue(OP_NOP, 2'd0);

        // 6: reset mid-loop then F(5)
        fib(8'd10, 4, it);
        out(R_A, 8'd3);
        issue(OP_NOP, 2'd0);
        do_reset();
        check_cleared("midrst");
        fib(8'd5, -1, it);
        chk("fib5_iters", it, 5);
        out(R_A, 8'd5);
        issue(OP_NOP, 2'd0);
        issue(OP_NOP, 2'd0);

        chk("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
